// File: rtl/jtframe_credits_wr_pkg.sv
// Shared definitions for the credits message map: address width derivation,
// tile word layout and the control byte codes understood by the writer.
package jtframe_credits_wr_pkg;

  function automatic int msgw_f(input int pages);
    if (pages <= 1)      return 10;
    else if (pages <= 2) return 11;
    else if (pages <= 4) return 12;
    else if (pages <= 8) return 13;
    else                 return 14;
  endfunction

  localparam int PAL_HI  = 8;
  localparam int PAL_LO  = 7;
  localparam int CHAR_HI = 6;
  localparam int CHAR_LO = 0;

  localparam logic [7:0] CC_PAL0 = 8'h01;
  localparam logic [7:0] CC_PAL1 = 8'h02;
  localparam logic [7:0] CC_PAL2 = 8'h03;
  localparam logic [7:0] CC_PAL3 = 8'h04;
  localparam logic [7:0] CC_TAB  = 8'h09;
  localparam logic [7:0] CC_LF   = 8'h0A;
  localparam logic [7:0] CC_FF   = 8'h0C;
  localparam logic [7:0] CC_CR   = 8'h0D;
  localparam logic [7:0] CC_HOME = 8'h1E;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADV,
    CUR_TAB,
    CUR_NL,
    CUR_CR,
    CUR_HOME
  } cur_op_e;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } wr_state_e;

endpackage

// File: rtl/jtframe_credits_cursor.sv
// Text cursor for the credits map: row/col counters with advance, tab,
// newline, carriage return and home; rows wrap at the last page row.
module jtframe_credits_cursor
  import jtframe_credits_wr_pkg::*;
#(
  parameter int PAGES = 1,
  parameter int RW    = 5
)(
  input  logic          clk,
  input  logic          rst_n,
  input  cur_op_e       op,
  output logic [RW-1:0] row,
  output logic [4:0]    col
);

  localparam logic [RW-1:0] LAST_ROW = RW'(PAGES*32-1);

  logic [RW-1:0] row_inc;

  always_comb begin
    row_inc = (row == LAST_ROW) ? '0 : row + RW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else begin
      unique case (op)
        CUR_ADV: begin
          col <= col + 5'd1;
          if (col == 5'd31) row <= row_inc;
        end
        CUR_TAB: begin
          // tab stops at 8, 16, 24; from the last stop it behaves as a newline
          if (col[4:3] == 2'b11) begin
            col <= '0;
            row <= row_inc;
          end else begin
            col <= {col[4:3] + 2'd1, 3'b000};
          end
        end
        CUR_NL: begin
          col <= '0;
          row <= row_inc;
        end
        CUR_CR:   col <= '0;
        CUR_HOME: begin
          col <= '0;
          row <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jtframe_credits_wr.sv
// Runtime writer for the credits tile map: decodes a text/control byte stream
// into tile words and runs a full-map clear after reset and on form feed.
module jtframe_credits_wr
  import jtframe_credits_wr_pkg::*;
#(
  parameter int         PAGES    = 1,
  parameter logic [6:0] CLR_CHAR = 7'h20,
  parameter logic [1:0] PAL_RST  = 2'd3,
  localparam int        MSGW     = msgw_f(PAGES)
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      din,
  input  logic            din_valid,
  output logic            din_ready,
  output logic [MSGW-1:0] msg_addr,
  output logic [8:0]      msg_data,
  output logic            msg_we,
  output logic [MSGW-6:0] cur_row,
  output logic [4:0]      cur_col,
  output logic            busy
);

  wr_state_e       state, state_nx;
  logic [MSGW:0]   clr_addr, clr_nx;
  logic [1:0]      pal, pal_nx;
  logic            we_nx, ready_nx, busy_nx;
  logic [MSGW-1:0] addr_nx;
  logic [8:0]      data_nx;
  cur_op_e         cur_op;
  logic            accept, printable;

  jtframe_credits_cursor #(
    .PAGES (PAGES),
    .RW    (MSGW-5)
  ) u_cursor (
    .clk   (clk),
    .rst_n (rst_n),
    .op    (cur_op),
    .row   (cur_row),
    .col   (cur_col)
  );

  always_comb begin
    state_nx  = state;
    clr_nx    = clr_addr;
    pal_nx    = pal;
    we_nx     = 1'b0;
    addr_nx   = msg_addr;
    data_nx   = msg_data;
    ready_nx  = din_ready;
    busy_nx   = busy;
    cur_op    = CUR_NONE;
    accept    = din_valid && din_ready;
    printable = !din[7] && (din[6:5] != 2'b00);
    unique case (state)
      ST_CLEAR: begin
        // the extra cycle after the last write keeps ready low for a full 2^MSGW window
        if (clr_addr[MSGW]) begin
          state_nx = ST_IDLE;
          ready_nx = 1'b1;
          busy_nx  = 1'b0;
          cur_op   = CUR_HOME;
        end else begin
          we_nx   = 1'b1;
          addr_nx = clr_addr[MSGW-1:0];
          data_nx = {pal, CLR_CHAR};
          clr_nx  = clr_addr + (MSGW+1)'(1);
        end
      end
      ST_IDLE: begin
        if (accept) begin
          if (printable) begin
            we_nx   = 1'b1;
            addr_nx = {cur_row, cur_col};
            data_nx[PAL_HI:PAL_LO]   = pal;
            data_nx[CHAR_HI:CHAR_LO] = din[6:0];
            cur_op  = CUR_ADV;
          end else begin
            unique case (din)
              CC_PAL0, CC_PAL1, CC_PAL2, CC_PAL3: pal_nx = din[1:0] - 2'd1;
              CC_TAB:  cur_op = CUR_TAB;
              CC_LF:   cur_op = CUR_NL;
              CC_CR:   cur_op = CUR_CR;
              CC_HOME: cur_op = CUR_HOME;
              CC_FF: begin
                // address 0 is written right away so the clear starts the next cycle
                state_nx = ST_CLEAR;
                we_nx    = 1'b1;
                addr_nx  = '0;
                data_nx  = {pal, CLR_CHAR};
                clr_nx   = (MSGW+1)'(1);
                ready_nx = 1'b0;
                busy_nx  = 1'b1;
                cur_op   = CUR_HOME;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_nx = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      clr_addr  <= '0;
      pal       <= PAL_RST;
      msg_we    <= 1'b0;
      msg_addr  <= '0;
      msg_data  <= '0;
      din_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_nx;
      clr_addr  <= clr_nx;
      pal       <= pal_nx;
      msg_we    <= we_nx;
      msg_addr  <= addr_nx;
      msg_data  <= data_nx;
      din_ready <= ready_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_jtframe_credits_wr.sv
// Bench for jtframe_credits_wr (PAGES=1): directed scenarios with literal
// expectations plus random byte traffic checked against a reference model.
module tb_jtframe_credits_wr;

  localparam int ROWS  = 32;
  localparam int DEPTH = 1024;
  localparam int CLRC  = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready, msg_we, busy;
  logic [9:0] msg_addr;
  logic [8:0] msg_data;
  logic [4:0] cur_row, cur_col;

  jtframe_credits_wr #(
    .PAGES    (1),
    .CLR_CHAR (7'h20),
    .PAL_RST  (2'd3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .msg_addr  (msg_addr),
    .msg_data  (msg_data),
    .msg_we    (msg_we),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_clr >= 0 means a clear is running and counts addresses
  // written so far; DEPTH means the last write is out and ready returns next.
  int m_clr, m_pal, m_row, m_col, m_we, m_addr, m_data;
  bit chk_on = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clr = 0; m_pal = 3; m_row = 0; m_col = 0;
      m_we = 0; m_addr = 0; m_data = 0;
    end else begin
      m_we = 0;
      if (m_clr >= 0) begin
        if (m_clr < DEPTH) begin
          m_we = 1; m_addr = m_clr; m_data = m_pal * 128 + CLRC;
          m_clr++;
        end else begin
          m_clr = -1; m_row = 0; m_col = 0;
        end
      end else if (din_valid) begin
        if (din >= 8'h20 && din <= 8'h7F) begin
          m_we = 1;
          m_addr = m_row * 32 + m_col;
          m_data = m_pal * 128 + int'(din) % 128;
          m_col++;
          if (m_col == 32) begin m_col = 0; m_row = (m_row + 1) % ROWS; end
        end else if (din >= 8'h01 && din <= 8'h04) begin
          m_pal = int'(din) - 1;
        end else if (din == 8'h09) begin
          m_col = (m_col / 8 + 1) * 8;
          if (m_col == 32) begin m_col = 0; m_row = (m_row + 1) % ROWS; end
        end else if (din == 8'h0A) begin
          m_col = 0; m_row = (m_row + 1) % ROWS;
        end else if (din == 8'h0D) begin
          m_col = 0;
        end else if (din == 8'h1E) begin
          m_col = 0; m_row = 0;
        end else if (din == 8'h0C) begin
          m_we = 1; m_addr = 0; m_data = m_pal * 128 + CLRC;
          m_clr = 1; m_row = 0; m_col = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_ready", int'(din_ready), int'(m_clr < 0));
      chk("m_busy", int'(busy), int'(m_clr >= 0));
      chk("m_we", int'(msg_we), m_we);
      chk("m_row", int'(cur_row), m_row);
      chk("m_col", int'(cur_col), m_col);
      if (m_we != 0) begin
        chk("m_addr", int'(msg_addr), m_addr);
        chk("m_data", int'(msg_data), m_data);
      end
    end
  end

  // Present a byte and hold it until accepted; returns on the negedge after acceptance.
  task automatic send(input logic [7:0] b);
    int t = 0;
    din = b;
    din_valid = 1'b1;
    while (!din_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("send_timeout", int'(t < 5000), 1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] ctl [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h09, 8'h0A, 8'h0D, 8'h1E};

  initial begin
    int n_wr, cnt, n_ff, r;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    chk("rst_we", int'(msg_we), 0);
    chk("rst_addr", int'(msg_addr), 0);
    chk("rst_data", int'(msg_data), 0);
    chk("rst_ready", int'(din_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_cursor", int'({cur_row, cur_col}), 0);
    chk_on = 1'b1;
    rst_n = 1'b1;

    n_wr = 0;
    for (int i = 1; i <= 1024; i++) begin
      @(negedge clk);
      if (msg_we && msg_data == 9'h1A0 && int'(msg_addr) == i - 1) n_wr++;
    end
    chk("boot_clear_writes", n_wr, 1024);
    @(negedge clk);
    chk("boot_ready_1025", int'(din_ready), 1);
    chk("boot_busy_1025", int'(busy), 0);
    chk("boot_cursor", int'({cur_row, cur_col}), 0);

    send(8'h02);
    chk("pal_no_write", int'(msg_we), 0);
    send(8'h41);
    chk("A_we", int'(msg_we), 1);
    chk("A_addr", int'(msg_addr), 0);
    chk("A_data", int'(msg_data), 9'h0C1);
    chk("A_col", int'(cur_col), 1);

    send(8'h1E);
    for (int i = 0; i < 33; i++) begin
      send(8'h42);
      if (i == 31) chk("B32_addr", int'(msg_addr), 31);
      if (i == 32) chk("B33_addr", int'(msg_addr), 32);
    end

    send(8'h1E);
    repeat (31) send(8'h0A);
    repeat (3) send(8'h09);
    repeat (7) send(8'h78);
    chk("at_31_31", int'({cur_row, cur_col}), 10'h3FF);
    send(8'h43);
    chk("C_addr", int'(msg_addr), 1023);
    chk("C_wrap", int'({cur_row, cur_col}), 0);
    repeat (31) send(8'h0A);
    chk("row31", int'(cur_row), 31);
    send(8'h0A);
    chk("lf_wrap", int'({cur_row, cur_col}), 0);

    send(8'h1E);
    repeat (3) send(8'h74);
    send(8'h09);
    chk("tab_3_8", int'(cur_col), 8);
    send(8'h09); send(8'h09);
    repeat (3) send(8'h74);
    send(8'h09);
    chk("tab27_row", int'(cur_row), 1);
    chk("tab27_col", int'(cur_col), 0);
    send(8'h71); send(8'h71);
    send(8'h0D);
    chk("cr_col", int'(cur_col), 0);
    chk("cr_row", int'(cur_row), 1);
    send(8'h07);
    chk("bel_no_write", int'(msg_we), 0);
    chk("bel_cursor", int'({cur_row, cur_col}), 10'h020);

    send(8'h01);
    send(8'h0C);
    chk("ff_ready_low", int'(din_ready), 0);
    din = 8'h44;
    din_valid = 1'b1;
    cnt = 0;
    while (!din_ready && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    chk("ff_window", cnt, 1024);
    @(negedge clk);
    din_valid = 1'b0;
    chk("D_we", int'(msg_we), 1);
    chk("D_addr", int'(msg_addr), 0);
    chk("D_data", int'(msg_data), 9'h044);

    n_ff = 0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 3);
      if (r != 0) begin
        din_valid = 1'b0;
        repeat (r) @(negedge clk);
      end
      r = $urandom_range(0, 99);
      if (r < 70) b = 8'(32 + $urandom_range(0, 95));
      else if (r < 85) b = ctl[$urandom_range(0, 7)];
      else if (r < 98) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0C) b = 8'h0B;
      end else if (n_ff < 3) begin
        b = 8'h0C;
        n_ff++;
      end else b = 8'h41;
      send(b);
    end
    din_valid = 1'b0;

    send(8'h0C);
    din_valid = 1'b0;
    repeat (200) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_we", int'(msg_we), 0);
    chk("abort_addr", int'(msg_addr), 0);
    chk("abort_ready", int'(din_ready), 0);
    chk("abort_busy", int'(busy), 1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) send(8'(32 + $urandom_range(0, 95)));
    din_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
